// File: rtl/mmu_tlb_walker_if.sv
// Shared cbus payload types and the pipeline/cbus interface of mmu_tlb_walker.
package mmu_tlb_walker_pkg;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 64;

  localparam logic [2:0] MSIZE8          = 3'd3;
  localparam logic [7:0] MLEN1           = 8'd0;
  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;

  typedef struct packed {
    logic              valid;
    logic              is_write;
    logic [ADDR_W-1:0] addr;
    logic [2:0]        size;
    logic [7:0]        len;
    logic [1:0]        burst;
  } cbus_req_t;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } cbus_resp_t;

endpackage

// Translation request/response port plus the page-table read bus.
interface mmu_tlb_walker_if;
  import mmu_tlb_walker_pkg::*;

  logic        req_valid;
  logic [63:0] req_vaddr;
  logic [1:0]  req_acc;
  logic        resp_valid;
  logic [63:0] resp_paddr;
  logic        resp_fault;
  cbus_req_t   creq;
  cbus_resp_t  cresp;

  modport slave (
    input  req_valid, req_vaddr, req_acc, cresp,
    output resp_valid, resp_paddr, resp_fault, creq
  );

  modport master (
    output req_valid, req_vaddr, req_acc, cresp,
    input  resp_valid, resp_paddr, resp_fault, creq
  );
endinterface

// File: rtl/mmu_tlb_walker.sv
// Page-table walker with a fully associative TLB, permission checks,
// superpage support and page-fault reporting. One translation at a time.
// Optional MMU_PERF_CNT_EN adds saturating hit/miss/fault counters.
module mmu_tlb_walker
  import mmu_tlb_walker_pkg::*;
#(
  parameter int unsigned LEVELS      = 3,
  parameter int unsigned TLB_ENTRIES = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  mmu_tlb_walker_if.slave        bus,
  input  logic [43:0]            satp_ppn,
  input  logic [3:0]             satp_mode,
  input  logic [1:0]             priviledgeMode,
  input  logic                   sfence
`ifdef MMU_PERF_CNT_EN
  ,
  output logic [31:0]            tlb_hit_cnt,
  output logic [31:0]            tlb_miss_cnt,
  output logic [31:0]            fault_cnt
`endif
);

  localparam int unsigned VA_BITS  = 12 + 9 * LEVELS;
  localparam int unsigned VPN_BITS = 9 * LEVELS;
  localparam int unsigned PTR_BITS = $clog2(TLB_ENTRIES);
  localparam int unsigned LVL_BITS = 2;

  typedef enum logic [2:0] {IDLE, LOOKUP, REQ, WAIT, CHECK, DONE} state_e;

  state_e               state_q, state_n;
  logic [VA_BITS-1:0]   vaddr_q, vaddr_n;
  logic [1:0]           acc_q, acc_n;
  logic [LVL_BITS-1:0]  lvl_q, lvl_n;
  logic [43:0]          base_q, base_n;
  logic [63:0]          pte_q, pte_n;
  cbus_req_t            creq_q, creq_n;
  logic                 resp_valid_q, resp_valid_n;
  logic [63:0]          resp_paddr_q, resp_paddr_n;
  logic                 resp_fault_q, resp_fault_n;
  logic                 pend_q, pend_n;
  logic                 fill;
  logic                 leaf_bad;

  // TLB storage; flags are {D, A, U, X, W, R}
  logic [TLB_ENTRIES-1:0] tlb_valid_q;
  logic [VPN_BITS-1:0]    tlb_vpn_q   [TLB_ENTRIES];
  logic [LVL_BITS-1:0]    tlb_lvl_q   [TLB_ENTRIES];
  logic [43:0]            tlb_ppn_q   [TLB_ENTRIES];
  logic [5:0]             tlb_flags_q [TLB_ENTRIES];
  logic [PTR_BITS-1:0]    rr_q;
  logic                   hit;
  logic [PTR_BITS-1:0]    hit_idx;

  logic unused_pte;
  assign unused_pte = ^{pte_q[63:54], pte_q[9:8], pte_q[5]};

  assign bus.creq       = creq_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_paddr = resp_paddr_q;
  assign bus.resp_fault = resp_fault_q;

  function automatic logic [5:0] pte_flags(input logic [63:0] pte);
    return {pte[7], pte[6], pte[4], pte[3], pte[2], pte[1]};
  endfunction

  // Leaf checks: superpage alignment, access permission, user bit, A and D.
  function automatic logic leaf_fault(input logic [5:0] f, input logic [43:0] ppn,
                                      input logic [LVL_BITS-1:0] lvl, input logic [1:0] acc,
                                      input logic [1:0] priv);
    logic [43:0] low;
    logic        perm;
    logic        usr;
    low = (44'(1) << (9 * lvl)) - 44'(1);
    case (acc)
      2'b00:   perm = !f[2];
      2'b01:   perm = !f[0];
      2'b10:   perm = !f[1];
      default: perm = 1'b1;
    endcase
    usr = (priv == 2'd0) ? !f[3] : f[3];
    return (|(ppn & low)) | perm | usr | !f[4] | ((acc == 2'b10) && !f[5]);
  endfunction

  // Physical address: PPN above the leaf level joined with the page offset.
  function automatic logic [63:0] make_paddr(input logic [43:0] ppn,
                                             input logic [LVL_BITS-1:0] lvl,
                                             input logic [VA_BITS-1:0] va);
    logic [55:0] m;
    m = (56'(1) << (12 + 9 * lvl)) - 56'(1);
    return {8'h00, ({ppn, 12'h000} & ~m) | (56'(va) & m)};
  endfunction

  // Associative lookup; each entry compares only VPN fields at or above its level.
  always_comb begin
    logic m;
    hit     = 1'b0;
    hit_idx = '0;
    for (int e = 0; e < TLB_ENTRIES; e++) begin
      m = tlb_valid_q[e];
      for (int i = 0; i < LEVELS; i++) begin
        if ((LVL_BITS'(i) >= tlb_lvl_q[e]) &&
            (vaddr_q[12 + 9 * i +: 9] != tlb_vpn_q[e][9 * i +: 9])) begin
          m = 1'b0;
        end
      end
      if (m && !hit) begin
        hit     = 1'b1;
        hit_idx = PTR_BITS'(e);
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_n      = state_q;
    vaddr_n      = vaddr_q;
    acc_n        = acc_q;
    lvl_n        = lvl_q;
    base_n       = base_q;
    pte_n        = pte_q;
    creq_n       = creq_q;
    resp_valid_n = 1'b0;
    resp_paddr_n = resp_paddr_q;
    resp_fault_n = resp_fault_q;
    pend_n       = pend_q | sfence;
    fill         = 1'b0;
    leaf_bad     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          vaddr_n = bus.req_vaddr[VA_BITS-1:0];
          acc_n   = bus.req_acc;
          pend_n  = 1'b0;
          if ((satp_mode == 4'd0) || (priviledgeMode == 2'd3)) begin
            resp_valid_n = 1'b1;
            resp_paddr_n = bus.req_vaddr;
            resp_fault_n = 1'b0;
            state_n      = DONE;
          end else if (!((&bus.req_vaddr[63:VA_BITS-1]) || !(|bus.req_vaddr[63:VA_BITS-1]))) begin
            resp_valid_n = 1'b1;
            resp_paddr_n = 64'h0;
            resp_fault_n = 1'b1;
            state_n      = DONE;
          end else begin
            state_n = LOOKUP;
          end
        end
      end
      LOOKUP: begin
        if (hit) begin
          leaf_bad     = leaf_fault(tlb_flags_q[hit_idx], tlb_ppn_q[hit_idx],
                                    tlb_lvl_q[hit_idx], acc_q, priviledgeMode);
          resp_valid_n = 1'b1;
          resp_fault_n = leaf_bad;
          resp_paddr_n = leaf_bad ? 64'h0
                                  : make_paddr(tlb_ppn_q[hit_idx], tlb_lvl_q[hit_idx], vaddr_q);
          state_n      = DONE;
        end else begin
          lvl_n   = LVL_BITS'(LEVELS - 1);
          base_n  = satp_ppn;
          state_n = REQ;
        end
      end
      REQ: begin
        creq_n.valid    = 1'b1;
        creq_n.is_write = 1'b0;
        creq_n.addr     = {8'h00, base_q, vaddr_q[12 + 9 * lvl_q +: 9], 3'b000};
        creq_n.size     = MSIZE8;
        creq_n.len      = MLEN1;
        creq_n.burst    = AXI_BURST_FIXED;
        state_n         = WAIT;
      end
      WAIT: begin
        if (bus.cresp.last) begin
          pte_n   = bus.cresp.data;
          creq_n  = '0;
          state_n = CHECK;
        end
      end
      CHECK: begin
        state_n = DONE;
        if (!pte_q[0] || (!pte_q[1] && pte_q[2])) begin
          resp_valid_n = 1'b1;
          resp_fault_n = 1'b1;
          resp_paddr_n = 64'h0;
        end else if (!pte_q[1] && !pte_q[3]) begin
          if (lvl_q == '0) begin
            resp_valid_n = 1'b1;
            resp_fault_n = 1'b1;
            resp_paddr_n = 64'h0;
          end else begin
            base_n  = pte_q[53:10];
            lvl_n   = lvl_q - LVL_BITS'(1);
            state_n = REQ;
          end
        end else begin
          leaf_bad     = leaf_fault(pte_flags(pte_q), pte_q[53:10], lvl_q, acc_q, priviledgeMode);
          resp_valid_n = 1'b1;
          resp_fault_n = leaf_bad;
          resp_paddr_n = leaf_bad ? 64'h0 : make_paddr(pte_q[53:10], lvl_q, vaddr_q);
          fill         = !leaf_bad && !pend_q && !sfence;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      vaddr_q      <= '0;
      acc_q        <= '0;
      lvl_q        <= '0;
      base_q       <= '0;
      pte_q        <= '0;
      creq_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_paddr_q <= '0;
      resp_fault_q <= 1'b0;
      pend_q       <= 1'b0;
    end else begin
      state_q      <= state_n;
      vaddr_q      <= vaddr_n;
      acc_q        <= acc_n;
      lvl_q        <= lvl_n;
      base_q       <= base_n;
      pte_q        <= pte_n;
      creq_q       <= creq_n;
      resp_valid_q <= resp_valid_n;
      resp_paddr_q <= resp_paddr_n;
      resp_fault_q <= resp_fault_n;
      pend_q       <= pend_n;
    end
  end

  // TLB valid bits and round-robin replacement pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tlb_valid_q <= '0;
      rr_q        <= '0;
    end else if (sfence) begin
      tlb_valid_q <= '0;
    end else if (fill) begin
      tlb_valid_q[rr_q] <= 1'b1;
      rr_q              <= rr_q + PTR_BITS'(1);
    end
  end

  // TLB payload written at the replacement pointer on a successful walk.
  always_ff @(posedge clk) begin
    if (fill) begin
      tlb_vpn_q[rr_q]   <= vaddr_q[VA_BITS-1:12];
      tlb_lvl_q[rr_q]   <= lvl_q;
      tlb_ppn_q[rr_q]   <= pte_q[53:10];
      tlb_flags_q[rr_q] <= pte_flags(pte_q);
    end
  end

`ifdef MMU_PERF_CNT_EN
  // Saturating performance counters; sfence leaves them untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tlb_hit_cnt  <= '0;
      tlb_miss_cnt <= '0;
      fault_cnt    <= '0;
    end else begin
      if ((state_q == LOOKUP) && hit && (tlb_hit_cnt != 32'hFFFF_FFFF))
        tlb_hit_cnt <= tlb_hit_cnt + 32'd1;
      if ((state_q == LOOKUP) && !hit && (tlb_miss_cnt != 32'hFFFF_FFFF))
        tlb_miss_cnt <= tlb_miss_cnt + 32'd1;
      if ((state_q == DONE) && resp_fault_q && (fault_cnt != 32'hFFFF_FFFF))
        fault_cnt <= fault_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/mmu_tlb_walker.md
Name: mmu_tlb_walker

Overview:
- Parametrised successor to the single-request page-table walker.
- Translates one virtual address at a time for a pipeline port (fetch, load or store).
- Adds a fully associative TLB, permission checks, superpage support and page-fault reporting.
- Sits between the pipeline memory stage and the cbus. Walks page tables with single-beat 8-byte reads on a TLB miss.

Parameters:
LEVELS, 3, page-table depth (3 = Sv39, 4 = Sv48); VA_BITS = 12 + 9*LEVELS
TLB_ENTRIES, 8, number of fully associative TLB entries (power of two, >= 2)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  translation request; held stable until resp_valid
- req_vaddr  in  64  virtual address
- req_acc  in  2  access type: 00 fetch, 01 load, 10 store
- resp_valid  out  1  one-cycle response pulse
- resp_paddr  out  64  physical address; valid when resp_valid=1 and resp_fault=0
- resp_fault  out  1  page fault for this request
- satp_ppn  in  44  root page-table PPN
- satp_mode  in  4  0 = bare; any other value = paged
- priviledgeMode  in  2  current privilege: 0 = U, 1 = S, 3 = M
- sfence  in  1  flush all TLB entries
- creq  out  cbus_req_t  page-table read request
- cresp  in  cbus_resp_t  page-table read response

Behaviour:
- Reset (asynchronous):
  - state = IDLE.
  - creq = 0, resp_valid = 0, resp_fault = 0, resp_paddr = 0.
  - All TLB valid bits cleared; round-robin pointer = 0.
  - Reset during a walk abandons it and drops creq.valid immediately.
- States: IDLE, LOOKUP, REQ, WAIT, CHECK, DONE.
- A request is accepted only in IDLE when req_valid=1. The vaddr and acc are registered at acceptance.
- Bypass: satp_mode==0 or priviledgeMode==3 → DONE. resp_paddr = vaddr, no fault. resp_valid asserts 1 cycle after acceptance.
- Canonical check: if vaddr[63:VA_BITS-1] is not all-equal → DONE with fault. No bus traffic.
- LOOKUP:
  - Compare VPN against every valid entry; each entry holds a level tag and compares only VPN fields above that level.
  - Hit: run the permission check with the stored flags → DONE. resp_valid asserts 2 cycles after acceptance.
  - Miss: lvl = LEVELS-1, base = satp_ppn → REQ.
- REQ:
  - creq.valid=1, addr={8'b0, base, vpn[lvl], 3'b0}.
  - size MSIZE8, len MLEN1, burst AXI_BURST_FIXED, is_write=0.
  - → WAIT.
- WAIT:
  - creq is held until cresp.last; then the PTE is latched, creq is cleared the next cycle, → CHECK.
- CHECK:
  - V=0, or (R=0 and W=1) → fault.
  - R=0 and X=0 (pointer): lvl==0 → fault; otherwise base = PTE[53:10], lvl -= 1, → REQ.
  - Leaf: fault if any of:
    - the PPN bits below lvl are nonzero (misaligned superpage);
    - permission failure: fetch needs X, load needs R, store needs W;
    - user check: U-mode needs U=1, S-mode faults on U=1;
    - A=0;
    - store with D=0.
  - There is no hardware A/D update.
  - On success:
    - paddr = {8'b0, PPN above lvl, vaddr bits [12+9*lvl-1:0]}.
    - Fill the TLB entry at the round-robin pointer, then increment the pointer modulo TLB_ENTRIES.
  - Faults never fill the TLB.
  - → DONE.
- DONE: resp_valid=1 for one cycle with resp_paddr and resp_fault → IDLE.
- sfence:
  - Clears all valid bits on the next edge.
  - If a walk is in flight, the walk completes and responds but does not fill the TLB.
  - sfence in the same cycle as a LOOKUP hit: the hit is still used.
- A change of satp does not flush the TLB; software issues sfence.

Optional Feature:
- Macro MMU_PERF_CNT_EN. When defined, adds three outputs: tlb_hit_cnt, tlb_miss_cnt and fault_cnt, each 32 bits.
- Counting rules:
  - tlb_hit_cnt increments on a LOOKUP hit.
  - tlb_miss_cnt increments on a LOOKUP miss.
  - fault_cnt increments on a DONE with fault.
  - All three saturate at 0xFFFF_FFFF, reset to 0, and are not cleared by sfence.
- When undefined, the ports and logic are absent. Translation behaviour is identical either way.

Test Plan:
- Three-level walk, load:
  - Setup: satp_mode=8, satp_ppn=0x80000, S-mode, vaddr 0x4000_1234.
  - Memory: 0x8000_0008=0x2000_0401, 0x8000_1000=0x2000_0801, 0x8000_2008=0x2004_8CC7.
  - Expect three creq reads at exactly those addresses, then resp_paddr=0x8012_3234, resp_fault=0.
- Following load to 0x4000_1FF8 → TLB hit. No creq.valid. resp_valid 2 cycles after acceptance, resp_paddr=0x8012_3FF8.
- Store to a page whose leaf PTE=0x2004_8C47 (D=0) → resp_fault=1, no TLB fill. A repeat store walks again (3 reads).
- Level-2 leaf PTE=0x2000_04CF (PPN 0x80001, misaligned gigapage) → resp_fault=1 after one read.
- satp_mode=0, vaddr 0x8000_0010 → resp_paddr=0x8000_0010 one cycle after acceptance; creq stays 0.
- Pulse sfence after the first scenario, then repeat the load to 0x4000_1234 → three walk reads again, same paddr. Assert reset during WAIT → creq.valid=0 immediately and state IDLE.
